// File: rtl/bus_arbiter_mux_if.sv
// Interface bundling the request side (gates, data, lock, mode) and the
// registered bus side (grant, index, bus value, valid) of bus_arbiter_mux.
// Optional conflict monitor signals exist only when BUS_CONFLICT_CHECK_EN is defined.
interface bus_arbiter_mux_if #(
  parameter int WIDTH = 16,
  parameter int N_SRC = 4,
  parameter int IDX_W = $clog2(N_SRC)
);
  logic [N_SRC-1:0]       Gate;
  logic [N_SRC*WIDTH-1:0] Data;
  logic                   Lock;
  logic                   RR_Mode;
  logic [N_SRC-1:0]       Grant;
  logic [IDX_W-1:0]       Grant_Idx;
  logic [WIDTH-1:0]       Bus_Out;
  logic                   Bus_Valid;
`ifdef BUS_CONFLICT_CHECK_EN
  logic                   Conflict;
  logic [15:0]            Conflict_Count;

  modport master (
    output Gate, Data, Lock, RR_Mode,
    input  Grant, Grant_Idx, Bus_Out, Bus_Valid, Conflict, Conflict_Count
  );
  modport slave (
    input  Gate, Data, Lock, RR_Mode,
    output Grant, Grant_Idx, Bus_Out, Bus_Valid, Conflict, Conflict_Count
  );
`else
  modport master (
    output Gate, Data, Lock, RR_Mode,
    input  Grant, Grant_Idx, Bus_Out, Bus_Valid
  );
  modport slave (
    input  Gate, Data, Lock, RR_Mode,
    output Grant, Grant_Idx, Bus_Out, Bus_Valid
  );
`endif
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered N_SRC-to-1 bus arbiter/multiplexer with run-time selectable
// fixed-priority or round-robin arbitration and multi-cycle bus lock.
// Optional feature macro: BUS_CONFLICT_CHECK_EN adds a registered Conflict
// flag and a saturating Conflict_Count of edges with more than one gate high.
module bus_arbiter_mux #(
  parameter int WIDTH = 16,
  parameter int N_SRC = 4,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic              Clk,
  input  logic              Reset,
  bus_arbiter_mux_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q;
  logic [N_SRC-1:0]   grant_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [WIDTH-1:0]   bus_out_q;
  logic               valid_q;

  logic [IDX_W-1:0]   fp_idx;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   win_idx_d;
  logic [WIDTH-1:0]   win_data;
  logic [WIDTH-1:0]   owner_data;
  logic               any_gate;
  logic               hold_owner;
  logic               multi_gate;
  int                 cand;

  // One-hot encode a source index.
  function automatic logic [N_SRC-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_SRC-1:0] v;
    v    = {N_SRC{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin pointer successor, wrapping after the last source.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
    if (w == IDX_W'(N_SRC - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return w + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Lowest asserted gate wins in fixed-priority mode (scan downward so the last hit is the lowest).
  always_comb begin
    fp_idx = {IDX_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.Gate[IDX_W'(i)]) begin
        fp_idx = IDX_W'(i);
      end else begin
        fp_idx = fp_idx;
      end
    end
  end

  // Round-robin search starting at the pointer, wrapping modulo N_SRC; scanning backwards keeps the closest hit.
  always_comb begin
    rr_idx = {IDX_W{1'b0}};
    cand   = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_SRC) begin
        cand = cand - N_SRC;
      end else begin
        cand = cand;
      end
      if (bus.Gate[IDX_W'(cand)]) begin
        rr_idx = IDX_W'(cand);
      end else begin
        rr_idx = rr_idx;
      end
    end
  end

  // Winner selection, lock-hold detection and source data muxing.
  always_comb begin
    any_gate   = |bus.Gate;
    multi_gate = |(bus.Gate & (bus.Gate - {{(N_SRC-1){1'b0}}, 1'b1}));
    if (bus.RR_Mode) begin
      win_idx_d = rr_idx;
    end else begin
      win_idx_d = fp_idx;
    end
    hold_owner = (state_q == ST_LOCKED) && bus.Gate[idx_q];
    win_data   = bus.Data[int'(win_idx_d) * WIDTH +: WIDTH];
    owner_data = bus.Data[int'(idx_q) * WIDTH +: WIDTH];
  end

  // Ownership FSM with registered grant, index, bus value and valid.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= {N_SRC{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      ptr_q     <= {IDX_W{1'b0}};
      bus_out_q <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      if (hold_owner) begin
        // Locked owner still requesting: keep it whatever else is asserted.
        bus_out_q <= owner_data;
        valid_q   <= 1'b1;
        state_q   <= bus.Lock ? ST_LOCKED : ST_OWNED;
      end else if (any_gate) begin
        grant_q   <= onehot(win_idx_d);
        idx_q     <= win_idx_d;
        bus_out_q <= win_data;
        valid_q   <= 1'b1;
        state_q   <= bus.Lock ? ST_LOCKED : ST_OWNED;
        if (bus.RR_Mode) begin
          ptr_q <= next_ptr(win_idx_d);
        end else begin
          ptr_q <= ptr_q;
        end
      end else begin
        // Idle: drop grant and valid, keep last bus value and owner index; Lock is ignored.
        grant_q <= {N_SRC{1'b0}};
        valid_q <= 1'b0;
        state_q <= ST_IDLE;
      end
    end
  end

  assign bus.Grant     = grant_q;
  assign bus.Grant_Idx = idx_q;
  assign bus.Bus_Out   = bus_out_q;
  assign bus.Bus_Valid = valid_q;

`ifdef BUS_CONFLICT_CHECK_EN
  logic        conflict_q;
  logic [15:0] conflict_cnt_q;

  // Flag and count edges where several gates were asserted together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      conflict_q     <= 1'b0;
      conflict_cnt_q <= 16'h0000;
    end else if (multi_gate) begin
      conflict_q <= 1'b1;
      if (conflict_cnt_q != 16'hFFFF) begin
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end else begin
        conflict_cnt_q <= conflict_cnt_q;
      end
    end else begin
      conflict_q <= 1'b0;
    end
  end

  assign bus.Conflict       = conflict_q;
  assign bus.Conflict_Count = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Self-checking bench for bus_arbiter_mux (N_SRC=4, WIDTH=16). Expected
// outputs are queued as stimulus is driven and compared after each edge.
module tb_bus_arbiter_mux;

  typedef struct packed {
    logic [3:0]  grant;
    logic [1:0]  idx;
    logic [15:0] bus;
    logic        valid;
  } obs_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  obs_t exp_q[$];
  obs_t obs_q[$];

  bus_arbiter_mux_if #(.WIDTH(16), .N_SRC(4), .IDX_W(2)) bif ();

  bus_arbiter_mux #(.WIDTH(16), .N_SRC(4), .IDX_W(2)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
    bif.Data = {d3, d2, d1, d0};
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bif.Gate = 4'b0000;
    bif.Lock = 1'b0;
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drive one edge of stimulus, queue its expectation and capture the outcome.
  task automatic cyc(input logic [3:0] g, input logic l, input logic rr,
                     input logic [3:0] eg, input logic [1:0] ei,
                     input logic [15:0] eb, input logic ev);
    obs_t e;
    obs_t o;
    e.grant = eg; e.idx = ei; e.bus = eb; e.valid = ev;
    bif.Gate = g; bif.Lock = l; bif.RR_Mode = rr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.grant = bif.Grant; o.idx = bif.Grant_Idx; o.bus = bif.Bus_Out; o.valid = bif.Bus_Valid;
    obs_q.push_back(o);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t e;
    obs_t o;
    set_data(16'h1000, 16'h1001, 16'h1002, 16'h1003);
    checks++;
    if ({bif.Grant, bif.Grant_Idx, bif.Bus_Out, bif.Bus_Valid} !== 23'd0) begin
      errors++;
      $display("FAIL reset_init grant=%b idx=%0d bus=%h valid=%b expected all zero",
               bif.Grant, bif.Grant_Idx, bif.Bus_Out, bif.Bus_Valid);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 16'h0000, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 16'h1002, 1'b1);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2, 16'h1002, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_seq got grant=%b idx=%0d bus=%h valid=%b expected grant=%b idx=%0d bus=%h valid=%b",
                 o.grant, o.idx, o.bus, o.valid, e.grant, e.idx, e.bus, e.valid);
      end
    end
    // Assert reset between edges while locked on source 2.
    rst = 1'b1;
    #1;
    checks++;
    if ({bif.Grant, bif.Grant_Idx, bif.Bus_Out, bif.Bus_Valid} !== 23'd0) begin
      errors++;
      $display("FAIL reset_async grant=%b idx=%0d bus=%h valid=%b expected all zero",
               bif.Grant, bif.Grant_Idx, bif.Bus_Out, bif.Bus_Valid);
    end
    bif.Gate = 4'b0000;
    bif.Lock = 1'b0;
    #1;
    rst = 1'b0;
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 16'h0000, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 16'h0000, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_release got grant=%b idx=%0d bus=%h valid=%b expected grant=%b idx=%0d bus=%h valid=%b",
                 o.grant, o.idx, o.bus, o.valid, e.grant, e.idx, e.bus, e.valid);
      end
    end
  endtask

  task automatic test_fixed_priority();
    obs_t e;
    obs_t o;
    reset_dut();
    set_data(16'h0000, 16'h1111, 16'h2222, 16'h3333);
    cyc(4'b1010, 1'b0, 1'b0, 4'b0010, 2'd1, 16'h1111, 1'b1);
    cyc(4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3, 16'h3333, 1'b1);
    cyc(4'b1100, 1'b0, 1'b0, 4'b0100, 2'd2, 16'h2222, 1'b1);
    cyc(4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0, 16'h0000, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fixed_prio got grant=%b idx=%0d bus=%h valid=%b expected grant=%b idx=%0d bus=%h valid=%b",
                 o.grant, o.idx, o.bus, o.valid, e.grant, e.idx, e.bus, e.valid);
      end
    end
  endtask

  task automatic test_round_robin();
    obs_t e;
    obs_t o;
    reset_dut();
    set_data(16'hA000, 16'hA001, 16'hA002, 16'hA003);
    cyc(4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 16'hA000, 1'b1);
    cyc(4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1, 16'hA001, 1'b1);
    cyc(4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 16'hA002, 1'b1);
    cyc(4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 16'hA003, 1'b1);
    cyc(4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 16'hA000, 1'b1);
    // Pointer now 1: sparse requests skip forward and wrap.
    cyc(4'b1001, 1'b0, 1'b1, 4'b1000, 2'd3, 16'hA003, 1'b1);
    cyc(4'b1001, 1'b0, 1'b1, 4'b0001, 2'd0, 16'hA000, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL round_robin got grant=%b idx=%0d bus=%h valid=%b expected grant=%b idx=%0d bus=%h valid=%b",
                 o.grant, o.idx, o.bus, o.valid, e.grant, e.idx, e.bus, e.valid);
      end
    end
  endtask

  task automatic test_lock();
    obs_t e;
    obs_t o;
    reset_dut();
    set_data(16'hA000, 16'hA001, 16'hA002, 16'hA003);
    cyc(4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 16'hA003, 1'b1);
    for (int n = 0; n < 3; n++) begin
      cyc(4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 16'hA003, 1'b1);
    end
    // Owner drops its gate: arbitration resumes from pointer 0.
    cyc(4'b0111, 1'b0, 1'b1, 4'b0001, 2'd0, 16'hA000, 1'b1);
    cyc(4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1, 16'hA001, 1'b1);
    // Lock on 3, then Lock=0 with Gate[3] still high holds one more edge, then arbitrates.
    cyc(4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 16'hA003, 1'b1);
    cyc(4'b1011, 1'b0, 1'b1, 4'b1000, 2'd3, 16'hA003, 1'b1);
    cyc(4'b1011, 1'b0, 1'b1, 4'b0001, 2'd0, 16'hA000, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lock got grant=%b idx=%0d bus=%h valid=%b expected grant=%b idx=%0d bus=%h valid=%b",
                 o.grant, o.idx, o.bus, o.valid, e.grant, e.idx, e.bus, e.valid);
      end
    end
  endtask

  task automatic test_idle_hold();
    obs_t e;
    obs_t o;
    reset_dut();
    set_data(16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC);
    cyc(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 16'hBEEF, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 16'hBEEF, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 16'hBEEF, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 16'h5678, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 16'h5678, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, 16'h1234, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL idle_hold got grant=%b idx=%0d bus=%h valid=%b expected grant=%b idx=%0d bus=%h valid=%b",
                 o.grant, o.idx, o.bus, o.valid, e.grant, e.idx, e.bus, e.valid);
      end
    end
  endtask

  task automatic test_mode_change();
    obs_t e;
    obs_t o;
    reset_dut();
    set_data(16'hA000, 16'hA001, 16'hA002, 16'hA003);
    cyc(4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 16'hA001, 1'b1);
    cyc(4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1, 16'hA001, 1'b1);
    cyc(4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0, 16'hA000, 1'b1);
    cyc(4'b1101, 1'b0, 1'b1, 4'b0100, 2'd2, 16'hA002, 1'b1);
    cyc(4'b0111, 1'b0, 1'b1, 4'b0001, 2'd0, 16'hA000, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mode_change got grant=%b idx=%0d bus=%h valid=%b expected grant=%b idx=%0d bus=%h valid=%b",
                 o.grant, o.idx, o.bus, o.valid, e.grant, e.idx, e.bus, e.valid);
      end
    end
  endtask

`ifdef BUS_CONFLICT_CHECK_EN
  task automatic test_conflict();
    logic [3:0] gseq [4];
    logic       cexp [4];
    gseq[0] = 4'b0110; gseq[1] = 4'b0110; gseq[2] = 4'b0110; gseq[3] = 4'b0100;
    cexp[0] = 1'b1;    cexp[1] = 1'b1;    cexp[2] = 1'b1;    cexp[3] = 1'b0;
    reset_dut();
    bif.RR_Mode = 1'b0;
    bif.Lock    = 1'b0;
    for (int n = 0; n < 4; n++) begin
      bif.Gate = gseq[n];
      @(posedge clk);
      #1;
      checks++;
      if (bif.Conflict !== cexp[n]) begin
        errors++;
        $display("FAIL conflict_flag step %0d got %b expected %b", n, bif.Conflict, cexp[n]);
      end
      @(negedge clk);
    end
    checks++;
    if (bif.Conflict_Count !== 16'd3) begin
      errors++;
      $display("FAIL conflict_count got %h expected 0003", bif.Conflict_Count);
    end
    // Drive the counter up to saturation with further conflicting edges.
    bif.Gate = 4'b1111;
    for (int n = 0; n < 65532; n++) begin
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (bif.Conflict_Count !== 16'hFFFF) begin
      errors++;
      $display("FAIL conflict_full got %h expected ffff", bif.Conflict_Count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bif.Conflict_Count !== 16'hFFFF || bif.Conflict !== 1'b1) begin
      errors++;
      $display("FAIL conflict_sat got count=%h flag=%b expected count=ffff flag=1",
               bif.Conflict_Count, bif.Conflict);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bif.Gate    = 4'b0000;
    bif.Data    = 64'd0;
    bif.Lock    = 1'b0;
    bif.RR_Mode = 1'b0;
    #2;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_lock();
    test_idle_hold();
    test_mode_change();
`ifdef BUS_CONFLICT_CHECK_EN
    test_conflict();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
